m_pte_port: RTL



---
 rtl/m_pte_port_pkg.sv | 35 +++
 rtl/m_pte_port_if.sv | 23 ++
 rtl/m_pte_port.sv | 137 +++++++++++++
 3 files changed

// File: rtl/m_pte_port_pkg.sv
// Shared encodings for the page-table memory port: port FSM states and MMU page-walk states.
package m_pte_port_pkg;

  typedef enum logic [2:0] {
    PP_IDLE     = 3'd0,
    PP_RD_REQ   = 3'd1,
    PP_RD_WAIT  = 3'd2,
    PP_WB_REQ   = 3'd3,
    PP_CPU_WAIT = 3'd4
  } pp_state_e;

  localparam logic [2:0] PW_IDLE    = 3'd0;
  localparam logic [2:0] PW_L1      = 3'd1;
  localparam logic [2:0] PW_L1_DONE = 3'd2;
  localparam logic [2:0] PW_L0      = 3'd3;
  localparam logic [2:0] PW_L0_DONE = 3'd4;
  localparam logic [2:0] PW_UPD     = 3'd5;
  localparam logic [2:0] PW_DONE    = 3'd7;

  // Walker states that wait for a PTE fetch from this port.
  function automatic logic pw_needs_read(input logic [2:0] s);
    return (s == PW_L1) || (s == PW_L0);
  endfunction

  // States that follow a fetch (or precede a walk): re-arm the one-shot read.
  function automatic logic pw_rearm(input logic [2:0] s);
    return (s == PW_IDLE) || (s == PW_L1_DONE) || (s == PW_L0_DONE);
  endfunction

  // The walker leaves the DRAM channel alone only when idle or finished.
  function automatic logic pw_cpu_window(input logic [2:0] s);
    return (s == PW_IDLE) || (s == PW_DONE);
  endfunction

endpackage

// File: rtl/m_pte_port_if.sv
// DRAM request/return channel shared by the page walker and the CPU path.
interface m_pte_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_mem_ack;
  logic                  w_mem_rvalid;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  modport master (
    output w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata,
    input  w_mem_ack, w_mem_rvalid, w_mem_rdata
  );

  modport slave (
    input  w_mem_req, w_mem_we, w_mem_addr, w_mem_wdata,
    output w_mem_ack, w_mem_rvalid, w_mem_rdata
  );
endinterface

// File: rtl/m_pte_port.sv
// Page-table memory port: turns MMU walk strobes into DRAM PTE reads, posts A/D write-backs,
// and arbitrates the DRAM channel between the walker and the CPU.
module m_pte_port
  import m_pte_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [2:0]            w_pw_state,
  input  logic                  w_tlb_acs,
  input  logic [ADDR_WIDTH-1:0] w_tlb_pte_addr,
  input  logic                  w_pte_we,
  input  logic [DATA_WIDTH-1:0] w_pte_wdata,
  input  logic                  w_cpu_req,
  input  logic                  w_cpu_we,
  input  logic [ADDR_WIDTH-1:0] w_cpu_addr,
  input  logic [DATA_WIDTH-1:0] w_cpu_wdata,
  output logic                  w_cpu_grant,
  output logic                  w_dram_busy,
  output logic [DATA_WIDTH-1:0] w_dram_odata,
  m_pte_port_if.master          mem
);

  pp_state_e             state;
  logic                  r_served;
  logic                  r_wb_pend;
  logic [ADDR_WIDTH-1:0] r_pte_addr;
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [DATA_WIDTH-1:0] r_odata;

  logic rd_start;
  logic cpu_ok;

  // A read start outranks everything; the write-back outranks the CPU.
  assign rd_start = (state == PP_IDLE) && pw_needs_read(w_pw_state) && !r_served;
  assign cpu_ok   = (state == PP_IDLE) && w_cpu_req && !rd_start && !r_wb_pend &&
                    pw_cpu_window(w_pw_state);

  assign w_cpu_grant  = cpu_ok;
  assign w_dram_busy  = (state != PP_IDLE) || r_wb_pend || rd_start;
  assign w_dram_odata = r_odata;

  // Command mux: walker commands come from registers, so they hold steady under backpressure.
  always_comb begin
    mem.w_mem_req   = 1'b0;
    mem.w_mem_we    = 1'b0;
    mem.w_mem_addr  = '0;
    mem.w_mem_wdata = '0;
    case (state)
      PP_RD_REQ: begin
        mem.w_mem_req  = 1'b1;
        mem.w_mem_addr = r_pte_addr;
      end
      PP_WB_REQ: begin
        mem.w_mem_req   = 1'b1;
        mem.w_mem_we    = 1'b1;
        mem.w_mem_addr  = r_wb_addr;
        mem.w_mem_wdata = r_wb_data;
      end
      PP_IDLE: begin
        if (cpu_ok) begin
          mem.w_mem_req   = 1'b1;
          mem.w_mem_we    = w_cpu_we;
          mem.w_mem_addr  = w_cpu_addr;
          mem.w_mem_wdata = w_cpu_wdata;
        end
      end
      default: ;
    endcase
  end

  // Control: FSM, one-shot read flag, posted-write pending flag, PTE read data.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= PP_IDLE;
      r_served  <= 1'b0;
      r_wb_pend <= 1'b0;
      r_odata   <= '0;
    end else begin
      if (pw_rearm(w_pw_state)) begin
        r_served <= 1'b0;
      end else if (rd_start) begin
        r_served <= 1'b1;
      end

      if (w_pte_we) begin
        r_wb_pend <= 1'b1;
      end else if ((state == PP_WB_REQ) && mem.w_mem_ack) begin
        r_wb_pend <= 1'b0;
      end

      case (state)
        PP_IDLE: begin
          if (rd_start) begin
            state <= PP_RD_REQ;
          end else if (r_wb_pend || w_pte_we) begin
            // Taking the fresh strobe directly lets the write request rise next cycle.
            state <= PP_WB_REQ;
          end else if (cpu_ok && mem.w_mem_ack && !w_cpu_we) begin
            state <= PP_CPU_WAIT;
          end
        end
        PP_RD_REQ: begin
          if (mem.w_mem_ack) state <= PP_RD_WAIT;
        end
        PP_RD_WAIT: begin
          if (mem.w_mem_rvalid) begin
            r_odata <= mem.w_mem_rdata;
            state   <= PP_IDLE;
          end
        end
        PP_WB_REQ: begin
          if (mem.w_mem_ack) state <= PP_IDLE;
        end
        PP_CPU_WAIT: begin
          if (mem.w_mem_rvalid) state <= PP_IDLE;
        end
        default: state <= PP_IDLE;
      endcase
    end
  end

  // Data capture: address register and the one-entry posted write buffer.
  always_ff @(posedge CLK) begin
    if ((state == PP_IDLE) && w_tlb_acs) begin
      r_pte_addr <= w_tlb_pte_addr;
    end
    if (w_pte_we) begin
      r_wb_addr <= w_tlb_pte_addr;
      r_wb_data <= w_pte_wdata;
    end
  end

endmodule
